// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - M-stage exception, ERET and CP0 access bus between pipeline and exc_ctrl
//
// Signals:
//   m_valid, pc_m, bd_m          M-stage instruction qualifier, PC, delay-slot flag
//   exc_valid_m, exc_code_m      synchronous exception raised by the M-stage instruction
//   eret_m                       M-stage instruction is ERET
//   hw_int[5:0]                  level-sensitive external interrupt lines
//   cp0_we, cp0_addr, cp0_wdata  MTC0 write port
//   cp0_rdata                    MFC0 read data (combinational on cp0_addr)
//   req                          take-exception pulse (PC loads handler vector, pipeline flushes)
//   eret_redirect, epc_out       ERET redirect and its target
// Modports: master = pipeline side, slave = exc_ctrl side.
interface exc_ctrl_if;
    logic        m_valid;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        exc_valid_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        req;
    logic        eret_redirect;
    logic [31:0] epc_out;

    modport master (
        output m_valid, pc_m, bd_m, exc_valid_m, exc_code_m, eret_m, hw_int,
        output cp0_we, cp0_addr, cp0_wdata,
        input  cp0_rdata, req, eret_redirect, epc_out
    );

    modport slave (
        input  m_valid, pc_m, bd_m, exc_valid_m, exc_code_m, eret_m, hw_int,
        input  cp0_we, cp0_addr, cp0_wdata,
        output cp0_rdata, req, eret_redirect, epc_out
    );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - CP0 exception controller: SR/Cause/EPC, exception entry and ERET return
//
// Ports:
//   clk    in  single clock, all state updates on the rising edge
//   reset  in  asynchronous active-low reset, clears all state immediately
//   bus    exc_ctrl_if.slave (M-stage inputs, CP0 port, req/eret_redirect/epc_out)
// Registers: SR (12) IM[15:10] EXL[1] IE[0]; Cause (13) BD[31] IP[15:10] ExcCode[6:2]; EPC (14).
// Optional feature: define INT_SYNC_EN to pass hw_int through a 2-flop synchronizer
// (ip lags hw_int by 2 cycles); otherwise ip follows hw_int combinationally.
module exc_ctrl (
    input  logic      clk,
    input  logic      reset,
    exc_ctrl_if.slave bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    // The FSM state is the SR.EXL bit itself.
    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

    state_t      state_q, state_nx;
    logic [5:0]  im_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;

    logic [5:0]  ip;
    logic        exl;
    logic        int_pend;
    logic        take;
    logic        eret_take;
    logic        wr_sr;
    logic        wr_epc;

`ifdef INT_SYNC_EN
    logic [5:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.hw_int;
            sync2_q <= sync1_q;
        end
    end

    assign ip = sync2_q;
`else
    assign ip = bus.hw_int;
`endif

    assign exl      = (state_q == HANDLER);
    assign int_pend = (|(ip & im_q)) & ie_q & ~exl;

    // Gating with reset keeps both pulses low while reset is held.
    assign take      = reset & bus.m_valid & ~exl & (int_pend | bus.exc_valid_m);
    assign eret_take = reset & bus.m_valid & bus.eret_m & ~take;

    // An exception in the same cycle wins over an MTC0.
    assign wr_sr  = bus.cp0_we & ~take & (bus.cp0_addr == ADDR_SR);
    assign wr_epc = bus.cp0_we & ~take & (bus.cp0_addr == ADDR_EPC);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next state: exception entry, then ERET return (which overrides an
    // MTC0 to EXL in the same cycle), then a plain MTC0 to SR.EXL.
    always_comb begin
        state_nx = state_q;
        if (take) begin
            state_nx = HANDLER;
        end else if (eret_take) begin
            state_nx = NORMAL;
        end else if (wr_sr) begin
            state_nx = state_t'(bus.cp0_wdata[1]);
        end
    end

    // CP0 datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= '0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            ip_q <= ip;
            if (take) begin
                bd_q   <= bus.bd_m;
                code_q <= int_pend ? 5'd0 : bus.exc_code_m;
                epc_q  <= bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
            end else begin
                if (wr_sr) begin
                    im_q <= bus.cp0_wdata[15:10];
                    ie_q <= bus.cp0_wdata[0];
                end
                if (wr_epc) begin
                    epc_q <= {bus.cp0_wdata[31:2], 2'b00};
                end
            end
        end
    end

    // Outputs
    always_comb begin
        bus.req           = take;
        bus.eret_redirect = eret_take;
        // ERET sees an MTC0 to EPC issued in the same cycle.
        if (bus.cp0_we && (bus.cp0_addr == ADDR_EPC)) begin
            bus.epc_out = {bus.cp0_wdata[31:2], 2'b00};
        end else begin
            bus.epc_out = epc_q;
        end
        case (bus.cp0_addr)
            ADDR_SR:    bus.cp0_rdata = {16'h0000, im_q, 8'h00, exl, ie_q};
            ADDR_CAUSE: bus.cp0_rdata = {bd_q, 15'h0000, ip_q, 3'b000, code_q, 2'b00};
            ADDR_EPC:   bus.cp0_rdata = epc_q;
            default:    bus.cp0_rdata = 32'h0000_0000;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^{bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl: vector table, directed sequences, random vs model
module tb_exc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_ctrl_if bus ();
    exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [5:0]  m_im, m_ipreg, h1, h2;
    logic        m_ie, m_exl, m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    // Model predictions for the current cycle
    logic        e_req, e_eret, e_intp;
    logic [5:0]  e_ip;
    logic [31:0] e_epc_out, e_rdata;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_im = '0; m_ipreg = '0; h1 = '0; h2 = '0;
        m_ie = 0; m_exl = 0; m_bd = 0; m_code = '0; m_epc = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd12) return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
        if (a == 5'd13) return (32'(m_bd) << 31) + (32'(m_ipreg) << 10) + (32'(m_code) << 2);
        if (a == 5'd14) return m_epc;
        return 32'h0;
    endfunction

    task automatic model_eval();
        if (!reset) model_reset();
        e_ip      = (SYNC_LAT != 0) ? h2 : bus.hw_int;
        e_intp    = ((e_ip & m_im) != 0) && m_ie && !m_exl;
        e_req     = reset && bus.m_valid && !m_exl && (e_intp || bus.exc_valid_m);
        e_eret    = reset && bus.m_valid && bus.eret_m && !e_req;
        e_epc_out = (bus.cp0_we && bus.cp0_addr == 5'd14) ? (bus.cp0_wdata & ~32'd3) : m_epc;
        e_rdata   = model_read(bus.cp0_addr);
    endtask

    task automatic model_commit();
        if (!reset) return;
        m_ipreg = e_ip;
        h2 = h1;
        h1 = bus.hw_int;
        if (e_req) begin
            m_exl  = 1;
            m_bd   = bus.bd_m;
            m_epc  = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
            m_code = e_intp ? 5'd0 : bus.exc_code_m;
        end else if (bus.cp0_we) begin
            if (bus.cp0_addr == 5'd12) begin
                m_im  = bus.cp0_wdata[15:10];
                m_exl = bus.cp0_wdata[1];
                m_ie  = bus.cp0_wdata[0];
            end else if (bus.cp0_addr == 5'd14) begin
                m_epc = bus.cp0_wdata & ~32'd3;
            end
        end
        if (e_eret) m_exl = 0;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.m_valid = 0; bus.pc_m = '0; bus.bd_m = 0; bus.exc_valid_m = 0;
        bus.exc_code_m = '0; bus.eret_m = 0; bus.cp0_we = 0; bus.cp0_addr = '0;
        bus.cp0_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we = 1; bus.cp0_addr = a; bus.cp0_wdata = d;
        tick();
        bus.cp0_we = 0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        check(name, bus.cp0_rdata, exp);
        tick();
    endtask

    task automatic step_check();
        #1;
        model_eval();
        check("rnd_req", 32'(bus.req), 32'(e_req));
        check("rnd_eret", 32'(bus.eret_redirect), 32'(e_eret));
        check("rnd_epc_out", bus.epc_out, e_epc_out);
        check("rnd_rdata", bus.cp0_rdata, e_rdata);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    initial begin
        reset = 0;
        bus.hw_int = '0;
        clear_inputs();

        vt[0] = '{5'd12, 32'hFFFF_FFFF, 32'h0000_FC03};
        vt[1] = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[2] = '{5'd14, 32'h0000_3007, 32'h0000_3004};
        vt[3] = '{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vt[4] = '{5'd12, 32'h0000_0401, 32'h0000_0401};
        vt[5] = '{5'd5,  32'h1234_5678, 32'h0000_0000};
        vt[6] = '{5'd12, 32'h0000_A802, 32'h0000_A802};
        vt[7] = '{5'd0,  32'hFFFF_FFFF, 32'h0000_0000};
        vt[8] = '{5'd12, 32'h0000_03FC, 32'h0000_0000};

        // Reset state
        do_reset();
        #1;
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_eret", 32'(bus.eret_redirect), 32'd0);
        @(negedge clk);
        read_chk("rst_sr", 5'd12, 32'h0);
        read_chk("rst_cause", 5'd13, 32'h0);
        read_chk("rst_epc", 5'd14, 32'h0);

        // CP0 write/readback table
        for (int i = 0; i < 9; i++) begin
            cp0_write(vt[i].addr, vt[i].wdata);
            read_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
        end

        // Interrupt entry, with a simultaneous exception losing on ExcCode
        do_reset();
        cp0_write(5'd12, 32'h0000_0401);
        bus.hw_int = 6'h01;
        repeat (SYNC_LAT) tick();
        bus.m_valid = 1; bus.pc_m = 32'h3010; bus.bd_m = 0;
        bus.exc_valid_m = 1; bus.exc_code_m = 5'd12;
        #1;
        check("int_req", 32'(bus.req), 32'd1);
        tick();
        clear_inputs();
        read_chk("int_epc", 5'd14, 32'h0000_3010);
        read_chk("int_cause", 5'd13, 32'h0000_0400);
        read_chk("int_sr", 5'd12, 32'h0000_0403);
        bus.hw_int = '0;

        // Exception in a delay slot
        do_reset();
        bus.m_valid = 0; bus.exc_valid_m = 1;
        #1;
        check("bubble_req", 32'(bus.req), 32'd0);
        tick();
        bus.m_valid = 1; bus.exc_valid_m = 1; bus.exc_code_m = 5'd12;
        bus.bd_m = 1; bus.pc_m = 32'h3000;
        #1;
        check("exc_req", 32'(bus.req), 32'd1);
        tick();
        clear_inputs();
        read_chk("exc_epc", 5'd14, 32'h0000_2FFC);
        read_chk("exc_cause", 5'd13, 32'h8000_0030);

        // No nesting while EXL=1, then ERET
        cp0_write(5'd12, 32'h0000_0403);
        bus.hw_int = 6'h01;
        repeat (SYNC_LAT + 1) tick();
        bus.m_valid = 1; bus.exc_valid_m = 1; bus.exc_code_m = 5'd4;
        #1;
        check("nest_req", 32'(bus.req), 32'd0);
        check("nest_eret", 32'(bus.eret_redirect), 32'd0);
        tick();
        bus.exc_valid_m = 0; bus.eret_m = 1;
        #1;
        check("eret_redirect", 32'(bus.eret_redirect), 32'd1);
        check("eret_epc_out", bus.epc_out, 32'h0000_2FFC);
        check("eret_req", 32'(bus.req), 32'd0);
        tick();
        clear_inputs();
        read_chk("eret_sr", 5'd12, 32'h0000_0401);
        bus.hw_int = '0;

        // MTC0 dropped under an exception; EPC write and ERET bypass
        do_reset();
        bus.m_valid = 1; bus.exc_valid_m = 1; bus.exc_code_m = 5'd4; bus.pc_m = 32'h100;
        bus.cp0_we = 1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'hFFFF_FFFF;
        #1;
        check("wdrop_req", 32'(bus.req), 32'd1);
        tick();
        clear_inputs();
        read_chk("wdrop_sr", 5'd12, 32'h0000_0002);
        bus.m_valid = 1; bus.eret_m = 1;
        bus.cp0_we = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_3007;
        #1;
        check("byp_eret", 32'(bus.eret_redirect), 32'd1);
        check("byp_epc_out", bus.epc_out, 32'h0000_3004);
        tick();
        clear_inputs();
        read_chk("byp_epc", 5'd14, 32'h0000_3004);
        read_chk("byp_sr", 5'd12, 32'h0000_0000);
        bus.m_valid = 1; bus.eret_m = 1;
        #1;
        check("eret_exl0", 32'(bus.eret_redirect), 32'd1);
        tick();
        clear_inputs();
        read_chk("eret_exl0_sr", 5'd12, 32'h0000_0000);

        // Reset asserted mid-HANDLER
        do_reset();
        cp0_write(5'd12, 32'h0000_FC01);
        bus.hw_int = 6'h3F;
        repeat (SYNC_LAT) tick();
        bus.m_valid = 1; bus.pc_m = 32'h4000;
        #1;
        check("mr_req", 32'(bus.req), 32'd1);
        tick();
        clear_inputs();
        #2;
        reset = 0;
        model_reset();
        bus.cp0_addr = 5'd12;
        bus.m_valid = 1; bus.exc_valid_m = 1; bus.eret_m = 1;
        #1;
        check("mr_sr", bus.cp0_rdata, 32'h0);
        check("mr_req0", 32'(bus.req), 32'd0);
        check("mr_eret0", 32'(bus.eret_redirect), 32'd0);
        bus.cp0_addr = 5'd13;
        #1;
        check("mr_cause", bus.cp0_rdata, 32'h0);
        bus.cp0_addr = 5'd14;
        #1;
        check("mr_epc", bus.cp0_rdata, 32'h0);
        clear_inputs();
        bus.hw_int = '0;
        @(negedge clk);
        reset = 1;
        bus.m_valid = 1; bus.exc_valid_m = 1; bus.exc_code_m = 5'd8; bus.pc_m = 32'h10;
        #1;
        check("mr_post_req", 32'(bus.req), 32'd1);
        tick();
        clear_inputs();
        read_chk("mr_post_cause", 5'd13, 32'h0000_0020);

        // Random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int sel;
            reset = ($urandom_range(0, 99) != 0);
            bus.m_valid     = ($urandom_range(0, 9) < 7);
            bus.pc_m        = $urandom;
            bus.bd_m        = $urandom_range(0, 1) == 1;
            bus.exc_valid_m = ($urandom_range(0, 9) < 2);
            bus.exc_code_m  = 5'($urandom);
            bus.eret_m      = ($urandom_range(0, 19) < 3);
            if ($urandom_range(0, 7) == 0) bus.hw_int = 6'($urandom);
            bus.cp0_we      = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            bus.cp0_addr    = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd13 : (sel == 2) ? 5'd14 : 5'($urandom);
            bus.cp0_wdata   = $urandom;
            step_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-003 SHALL have: m_valid  in  1  valid instruction in M stage (0 = bubble).
REQ-004 SHALL have: pc_m  in  32  PC of M-stage instruction.
REQ-005 SHALL have: bd_m  in  1  M-stage instruction is in a branch delay slot.
REQ-006 SHALL have: exc_valid_m  in  1  synchronous exception raised by M-stage instruction.
REQ-007 SHALL have: exc_code_m  in  5  ExcCode for exc_valid_m.
REQ-008 SHALL have: eret_m  in  1  M-stage instruction is ERET.
REQ-009 SHALL have: hw_int  in  6  level-sensitive external interrupt lines.
REQ-010 SHALL have: cp0_we, cp0_addr[4:0], cp0_wdata[31:0]  in  MTC0 write port; cp0_rdata  out  32  MFC0 read data, combinational on cp0_addr.
REQ-011 SHALL have: req  out  1  take-exception pulse to PC/pipeline (PC loads 0x0000_4180, pipeline flushes).
REQ-012 SHALL have: eret_redirect  out  1, epc_out  out  32  ERET redirect and target.

Function
REQ-013 SHALL hold SR (reg 12: IM[15:10], EXL[1], IE[0]; other bits read 0), Cause (reg 13: BD[31], IP[15:10], ExcCode[6:2]; others 0), EPC (reg 14); other addresses read 0.
REQ-014 SHALL implement two states: NORMAL (EXL=0) and HANDLER (EXL=1).
REQ-015 SHALL compute int_pend = |(ip & IM) & IE & ~EXL, where ip is hw_int (or synchronized copy, REQ-028).
REQ-016 SHALL drive req = m_valid & ~EXL & (int_pend | exc_valid_m), combinationally, same cycle.
REQ-017 SHALL give interrupt priority over exception: on req with int_pend, ExcCode=0; otherwise ExcCode=exc_code_m.
REQ-018 SHALL on req edge: EXL<=1, BD<=bd_m, EPC<=bd_m ? pc_m-4 : pc_m (32-bit wraparound), ExcCode loaded; state -> HANDLER.
REQ-019 SHALL update Cause.IP from ip every cycle regardless of state; IP not CP0-writable.
REQ-020 SHALL drive eret_redirect = m_valid & eret_m & ~req, epc_out = EPC (ERET bypass: if cp0_we to EPC same cycle, epc_out = cp0_wdata & ~3).
REQ-021 SHALL clear EXL on eret_redirect edge; state -> NORMAL; ERET with EXL=0 still redirects, EXL stays 0.
REQ-022 SHALL write SR IM/EXL/IE and EPC (low 2 bits forced 0) on cp0_we; Cause writes ignored.
REQ-023 SHALL suppress cp0_we when req is high same cycle (exception wins).
REQ-024 SHALL ignore exc_valid_m and interrupts while EXL=1 (no nesting); m_valid=0 never asserts req.
REQ-025 SHALL never assert req and eret_redirect in same cycle.

Reset
REQ-026 SHALL on reset low: SR=0, Cause=0, EPC=0, state NORMAL, synchronizer flops 0; req=eret_redirect=0 while reset low.
REQ-027 SHALL abandon any in-progress exception/ERET if reset asserts mid-cycle; no partial register update.

Configuration
REQ-028 SHALL, with INT_SYNC_EN defined, pass hw_int through a 2-flop synchronizer (ip lags hw_int by 2 cycles); without it, ip = hw_int combinationally (0 latency).

Verification
REQ-029 SHALL test: SR=0x0000_0401, hw_int[0]=1, m_valid=1, pc_m=0x3010, bd_m=0 -> req=1 (after 2 cycles if INT_SYNC_EN), EPC=0x3010, Cause.ExcCode=0, EXL=1.
REQ-030 SHALL test: exc_valid_m=1, code=12, bd_m=1, pc_m=0x3000 -> req=1, EPC=0x2FFC, Cause=0x8000_0030.
REQ-031 SHALL test: EXL=1, exc_valid_m=1 and interrupt pending -> req=0; then eret_m=1 -> eret_redirect=1, epc_out=EPC, EXL=0 next cycle.
REQ-032 SHALL test: cp0_we to reg 12 with wdata=0xFFFF_FFFF and simultaneous exception -> SR write dropped, EXL=1; cp0_we to reg 14 with 0x3007 -> EPC reads 0x3004.
REQ-033 SHALL test: reset low mid-HANDLER -> SR, Cause, EPC read 0 immediately, req=0, state NORMAL after release.
